// File: rtl/slink_apb_initiator.sv
// APB3 initiator for S-Link register blocks: turns a valid/ready register
// request channel into one APB transfer at a time, with wait-state support,
// slave-error reporting, a hung-slave timeout and a saturating error counter.
module slink_apb_initiator #(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                     RegClk,
    input  logic                     RegReset_n,
    // host-side request channel
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic [31:0]              req_wdata,
    // host-side response channel
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    // debug observation
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    input  logic                     err_count_clr,
    // APB3 requester
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_WIDTH-1:0]    PADDR,
    output logic [31:0]              PWDATA,
    input  logic [31:0]              PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] tcnt_q;
    logic            accept;
    logic            done_ok;
    logic            done_to;
    logic            resp_err_in;

    // APB control and handshakes decode straight from state, so an async
    // reset drops PSEL/PENABLE/rsp_valid without waiting for a clock.
    assign req_ready   = (state_q == ST_IDLE);
    assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign resp_err_in = done_to | (done_ok & PSLVERR);

    // State register
    always_ff @(posedge RegClk or negedge RegReset_n) begin
        if (!RegReset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; PREADY wins over a timeout in the same cycle
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    done_ok = 1'b1;
                    state_d = ST_RESP;
                end else if (TO_EN && (tcnt_q == TO_LAST)) begin
                    done_to = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Request capture, timeout counter, response and error counter registers
    always_ff @(posedge RegClk or negedge RegReset_n) begin
        if (!RegReset_n) begin
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            tcnt_q      <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            err_count   <= '0;
        end else begin
            if (accept) begin
                PWRITE <= req_write;
                PADDR  <= req_addr;
                PWDATA <= req_write ? req_wdata : '0;
            end

            if (accept) begin
                tcnt_q <= '0;
            end else if ((state_q == ST_ACCESS) && !PREADY) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            if (done_ok) begin
                rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (done_to) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end

            if (err_count_clr) begin
                err_count <= '0;
            end else if (resp_err_in && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slink_apb_initiator.sv
// Self-checking bench for slink_apb_initiator: a table of transfers driven
// through the request channel with a scripted APB responder, responses
// checked through a scoreboard queue, plus a hand-written mid-transfer reset.
module tb_slink_apb_initiator;

    logic        RegClk = 1'b0;
    logic        RegReset_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [1:0]  err_count;
    logic        err_count_clr;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;     // ACCESS cycles with PREADY low before PREADY
        bit          slverr;
        int          bp;        // RESP cycles with rsp_ready low
        bit          clr;       // pulse err_count_clr on the completing edge
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_acc;   // expected number of ACCESS cycles
        int          exp_cnt;   // expected err_count once in RESP
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    slink_apb_initiator #(
        .ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(4),
        .ERR_CNT_WIDTH(2)
    ) dut (
        .RegClk(RegClk),
        .RegReset_n(RegReset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .err_count(err_count),
        .err_count_clr(err_count_clr),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 RegClk = ~RegClk;

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: act=%h req=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit w, input logic [7:0] a, input logic [31:0] wd,
                                input logic [31:0] prd, input int wt, input bit se,
                                input int bp, input bit clr, input logic [31:0] er,
                                input bit ee, input bit et, input int ea, input int ec);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.prdata = prd; v.waits = wt;
        v.slverr = se; v.bp = bp; v.clr = clr; v.exp_rdata = er; v.exp_err = ee;
        v.exp_to = et; v.exp_acc = ea; v.exp_cnt = ec;
        return v;
    endfunction

    // Drives one transfer from accept to response handshake; all sampling and
    // driving happens on the falling edge.
    task automatic run_vec(input vec_t v);
        int   n;
        int   acc;
        exp_t e;
        exp_t g;
        logic [31:0] exp_pwdata;
        exp_pwdata = v.write ? v.wdata : 32'h0;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge RegClk);
            n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        @(negedge RegClk);
        // SETUP: scramble request inputs to show they are no longer sampled
        req_valid = 1'b0; req_write = ~v.write; req_addr = ~v.addr; req_wdata = $urandom;
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
        sb.push_back(e);
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_req_ready", 32'(req_ready), 32'd0);
        chk("setup_paddr", 32'(PADDR), 32'(v.addr));
        chk("setup_pwrite", 32'(PWRITE), 32'(v.write));
        chk("setup_pwdata", PWDATA, exp_pwdata);
        @(negedge RegClk);
        acc = 0;
        while (PSEL && PENABLE && acc < 20) begin
            chk("access_paddr", 32'(PADDR), 32'(v.addr));
            chk("access_pwdata", PWDATA, exp_pwdata);
            PREADY        = (acc == v.waits);
            PSLVERR       = v.slverr && (acc == v.waits);
            PRDATA        = (acc == v.waits) ? v.prdata : $urandom;
            err_count_clr = v.clr && (acc == v.waits);
            acc++;
            @(negedge RegClk);
            PREADY = 1'b0; PSLVERR = 1'b0; err_count_clr = 1'b0;
        end
        chk("access_cycles", 32'(acc), 32'(v.exp_acc));
        chk("resp_psel", 32'(PSEL), 32'd0);
        chk("resp_penable", 32'(PENABLE), 32'd0);
        chk("err_count", 32'(err_count), 32'(v.exp_cnt));
        for (int i = 0; i < v.bp; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_psel", 32'(PSEL), 32'd0);
            chk("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("bp_rsp_err", 32'(rsp_err), 32'(v.exp_err));
            req_valid = 1'b1; req_write = 1'b1; req_addr = $urandom;
            @(negedge RegClk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL scoreboard_empty: act=0 req=1");
        end else begin
            g = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, g.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(g.err));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(g.to));
        end
        @(negedge RegClk);
        rsp_ready = 1'b0;
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        RegReset_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; err_count_clr = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;

        //           w  addr   wdata         prdata        wt se bp clr exp_rdata     ee et acc cnt
        vecs[0]  = mk(1, 8'h0C, 32'h0064000A, 32'h11111111, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0);
        vecs[1]  = mk(0, 8'h10, 32'hCAFEF00D, 32'h0000F020, 3, 0, 0, 0, 32'h0000F020, 0, 0, 4, 0);
        vecs[2]  = mk(0, 8'h40, 32'h0,        32'hDEADBEEF, 0, 1, 0, 0, 32'h0,        1, 0, 1, 1);
        vecs[3]  = mk(0, 8'h20, 32'h0,        32'h55AA55AA, 9, 0, 0, 0, 32'h0,        1, 1, 4, 2);
        vecs[4]  = mk(0, 8'h24, 32'h0,        32'h12345678, 3, 0, 0, 0, 32'h12345678, 0, 0, 4, 2);
        vecs[5]  = mk(1, 8'h30, 32'hA5A55A5A, 32'h77777777, 1, 0, 5, 0, 32'h0,        0, 0, 2, 2);
        vecs[6]  = mk(1, 8'h44, 32'h00000001, 32'h0,        0, 1, 0, 1, 32'h0,        1, 0, 1, 0);
        vecs[7]  = mk(0, 8'h50, 32'h0,        32'h00000001, 0, 1, 0, 0, 32'h0,        1, 0, 1, 1);
        vecs[8]  = mk(0, 8'h54, 32'h0,        32'h00000002, 1, 1, 0, 0, 32'h0,        1, 0, 2, 2);
        vecs[9]  = mk(0, 8'h58, 32'h0,        32'h00000003, 0, 1, 0, 0, 32'h0,        1, 0, 1, 3);
        vecs[10] = mk(0, 8'h5C, 32'h0,        32'h00000004, 2, 1, 1, 0, 32'h0,        1, 0, 3, 3);
        vecs[11] = mk(1, 8'h60, 32'hFFFF0000, 32'h00000005, 0, 1, 0, 0, 32'h0,        1, 0, 1, 3);

        #12;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge RegClk);
        RegReset_n = 1'b1;
        @(negedge RegClk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during an ACCESS wait state: everything drops asynchronously
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h68; req_wdata = '0;
        @(negedge RegClk);
        req_valid = 1'b0;
        @(negedge RegClk);
        chk("mid_penable", 32'(PENABLE), 32'd1);
        #2;
        RegReset_n = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        @(negedge RegClk);
        RegReset_n = 1'b1;
        @(negedge RegClk);
        chk("mid_rel_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        run_vec(mk(0, 8'h08, 32'h0, 32'h0BADC0DE, 0, 0, 0, 0, 32'h0BADC0DE, 0, 0, 1, 0));

        if (sb.size() != 0) begin
            checks++; fails++;
            $display("FAIL scoreboard_leftover: act=%0d req=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
